// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and feeds IF/ID.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_write,
  input  logic                   redirect_en,
  input  logic [31:0]            redirect_pc,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            if_inst,
  output logic [31:0]            if_pc,
  output logic                   if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HAVE, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst_q, inst_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_q    <= NOP_INST;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      inst_q    <= inst_next;
      drop_addr <= drop_addr_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    inst_next      = inst_q;
    drop_addr_next = drop_addr;
    imem.req       = 1'b0;
    imem.addr      = pc;
    if_valid       = 1'b0;
    if_inst        = NOP_INST;
    if_pc          = pc;

    case (state)
      IDLE: state_next = FETCH;

      // A redirect without ack leaves the old request in flight; DROP keeps
      // presenting its address until memory answers, then the data is thrown away.
      FETCH: begin
        imem.req = 1'b1;
        if (redirect_en) begin
          pc_next = redirect_target;
          if (!imem.ack) begin
            drop_addr_next = pc;
            state_next     = DROP;
          end
        end else if (imem.ack) begin
          inst_next  = imem.rdata;
          state_next = HAVE;
        end
      end

      HAVE: begin
        if_valid = 1'b1;
        if_inst  = inst_q;
        if (redirect_en) begin
          pc_next    = redirect_target;
          state_next = FETCH;
        end else if (pc_write) begin
          pc_next    = pc + PC_STEP;
          state_next = FETCH;
        end
      end

      DROP: begin
        imem.req  = 1'b1;
        imem.addr = drop_addr;
        if (redirect_en) pc_next = redirect_target;
        if (imem.ack) state_next = FETCH;
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == FETCH && imem.ack && !redirect_en && fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (state == HAVE && !pc_write && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: tracks the outstanding request and the held instruction
  logic [31:0] m_pc, m_req_addr, m_inst;
  bit          m_started, m_outstanding, m_discard, m_have;
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  if_fetch_stage_if imem ();

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST),
    .PC_STEP  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutputs();
    checkOutput("imem_req", {31'd0, imem.req}, {31'd0, m_outstanding});
    if (m_outstanding) checkOutput("imem_addr", imem.addr, m_req_addr);
    checkOutput("if_valid", {31'd0, if_valid}, {31'd0, m_have});
    checkOutput("if_inst", if_inst, m_have ? m_inst : NOP_INST);
    checkOutput("if_pc", if_pc, m_pc);
`ifdef IF_PERF_CNT_EN
    checkOutput("fetch_cnt", fetch_cnt, m_fetch_cnt);
    checkOutput("stall_cnt", stall_cnt, m_stall_cnt);
`endif
  endtask

  task automatic modelReset();
    m_pc          = RESET_PC;
    m_req_addr    = RESET_PC;
    m_inst        = NOP_INST;
    m_started     = 1'b0;
    m_outstanding = 1'b0;
    m_discard     = 1'b0;
    m_have        = 1'b0;
    m_fetch_cnt   = '0;
    m_stall_cnt   = '0;
  endtask

  task automatic modelStep(input bit pw, input bit re, input logic [31:0] rpc,
                           input bit ack, input logic [31:0] rdata);
    logic [31:0] target;
    target = rpc & 32'hFFFF_FFFC;
    if (m_have && !pw && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (!m_started) begin
      m_started     = 1'b1;
      m_outstanding = 1'b1;
      m_req_addr    = m_pc;
      m_discard     = 1'b0;
    end else if (m_outstanding) begin
      if (ack) begin
        if (m_discard || re) begin
          if (re) m_pc = target;
          m_req_addr = m_pc;
          m_discard  = 1'b0;
        end else begin
          m_outstanding = 1'b0;
          m_have        = 1'b1;
          m_inst        = rdata;
          if (m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt++;
        end
      end else if (re) begin
        m_pc      = target;
        m_discard = 1'b1;
      end
    end else if (m_have && (re || pw)) begin
      m_pc          = re ? target : m_pc + 32'd4;
      m_have        = 1'b0;
      m_outstanding = 1'b1;
      m_req_addr    = m_pc;
      m_discard     = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit pw, input bit re, input logic [31:0] rpc,
                               input bit ack, input logic [31:0] rdata);
    pc_write    = pw;
    redirect_en = re;
    redirect_pc = rpc;
    imem.ack    = ack;
    imem.rdata  = rdata;
    @(posedge clk);
    modelStep(pw, re, rpc, ack, rdata);
    #1;
    checkOutputs();
  endtask

  // Reset takes effect asynchronously, so outputs are checked 1 time unit after assertion
  task automatic doReset();
    reset       = 1'b1;
    pc_write    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    imem.ack    = 1'b0;
    imem.rdata  = '0;
    #1;
    modelReset();
    checkOutputs();
    checkOutput("reset_req", {31'd0, imem.req}, 32'd0);
    checkOutput("reset_inst", if_inst, NOP_INST);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] word;
    bit          ack_now;

    doReset();

    // Sequential fetch with a one-cycle memory
    applyStimulus(1, 0, '0, 0, '0);
    checkOutput("s1_first_addr", imem.addr, 32'h0000_3000);
    for (int i = 0; i < 3; i++) begin
      word = $urandom;
      applyStimulus(1, 0, '0, 1, word);
      checkOutput("s1_inst", if_inst, word);
      checkOutput("s1_valid", {31'd0, if_valid}, 32'd1);
      if (i < 2) begin
        applyStimulus(1, 0, '0, 0, '0);
        checkOutput("s1_next_addr", imem.addr, 32'h0000_3000 + 32'(4 * (i + 1)));
      end
    end

    // Five stall cycles while holding an instruction
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, '0, 0, '0);
      checkOutput("s2_frozen_pc", if_pc, 32'h0000_3008);
      checkOutput("s2_no_req", {31'd0, imem.req}, 32'd0);
    end
`ifdef IF_PERF_CNT_EN
    checkOutput("s2_stall_cnt", stall_cnt, 32'd5);
`endif

    // Redirect while holding; low address bits must be cleared
    applyStimulus(1, 1, 32'h0000_3102, 0, '0);
    checkOutput("s3_redirect_addr", imem.addr, 32'h0000_3100);
    checkOutput("s3_bubble", {31'd0, if_valid}, 32'd0);

    // Redirect while the memory is slow: old request stays until its ack
    applyStimulus(1, 0, '0, 0, '0);
    applyStimulus(1, 1, 32'h0000_4000, 0, '0);
    checkOutput("s4_addr_held", imem.addr, 32'h0000_3100);
    applyStimulus(1, 0, '0, 0, '0);
    checkOutput("s4_addr_held2", imem.addr, 32'h0000_3100);
    applyStimulus(1, 0, '0, 1, 32'hBAD0_BAD0);
    checkOutput("s4_new_addr", imem.addr, 32'h0000_4000);
    checkOutput("s4_no_stale", if_inst, NOP_INST);
`ifdef IF_PERF_CNT_EN
    checkOutput("s4_fetch_cnt", fetch_cnt, 32'd3);
`endif
    applyStimulus(1, 0, '0, 1, 32'h1234_5678);
    checkOutput("s4_inst", if_inst, 32'h1234_5678);

    // PC wrap at the top of the address space
    applyStimulus(1, 1, 32'hFFFF_FFFC, 0, '0);
    applyStimulus(0, 0, '0, 1, 32'hCAFE_F00D);
    checkOutput("s5_top_pc", if_pc, 32'hFFFF_FFFC);
    applyStimulus(1, 0, '0, 0, '0);
    checkOutput("s5_wrap_addr", imem.addr, 32'h0000_0000);

    // Reset while a request is pending
    checkOutput("s6_req_before", {31'd0, imem.req}, 32'd1);
    doReset();
    applyStimulus(1, 0, '0, 0, '0);
    checkOutput("s6_first_addr", imem.addr, 32'h0000_3000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset();
      end else begin
        ack_now = m_outstanding && ($urandom_range(0, 2) != 0);
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      $urandom, ack_now, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
